// File: rtl/uart_tx_ctrl_if.sv
// Byte-transfer bundle between the TX FIFO, the sequencer and the UART
// transmitter. The sequencer takes the master side; the FIFO and the
// transmitter together make up the slave side.
interface uart_tx_ctrl_if #(
  parameter int D_W = 8
);
  logic           ff_empty;
  logic [D_W-1:0] ff_data;
  logic           ff_rd_en;
  logic [D_W-1:0] tx_data;
  logic           tx_start;
  logic           tx_done;

  modport master (
    input  ff_empty, ff_data, tx_done,
    output ff_rd_en, tx_data, tx_start
  );

  modport slave (
    output ff_empty, ff_data, tx_done,
    input  ff_rd_en, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Transmit-path sequencer: pops bytes from the TX FIFO, hands each one to
// the UART transmitter with a start pulse, waits for frame completion and
// then idles for a programmable number of baud ticks. A flush drains the
// FIFO without transmitting anything.
module uart_tx_ctrl #(
  parameter int D_W   = 8,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  input  logic [GAP_W-1:0] gap_ticks,
  input  logic             b_en,
  uart_tx_ctrl_if.master   bus,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    SEND,
    GAP,
    FL_POP,
    FL_WAIT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [GAP_W-1:0] gap_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; flush wins over enable, and neither level is looked
  // at outside IDLE/FL_WAIT, so a frame and its gap always run to the end.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (flush && !bus.ff_empty) begin
          next_state = FL_POP;
        end else if (enable && !bus.ff_empty) begin
          next_state = POP;
        end
      end
      POP:   next_state = LATCH;
      LATCH: next_state = START;
      START: next_state = SEND;
      SEND: begin
        if (bus.tx_done) begin
          next_state = (gap_ticks == '0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (b_en && (gap_cnt == GAP_W'(1))) begin
          next_state = IDLE;
        end
      end
      FL_POP: next_state = FL_WAIT;
      FL_WAIT: begin
        next_state = (flush && !bus.ff_empty) ? FL_POP : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered strobes, decoded from the state being entered so that each
  // is high for exactly the POP/FL_POP or START cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ff_rd_en <= 1'b0;
      bus.tx_start <= 1'b0;
    end else begin
      bus.ff_rd_en <= (next_state == POP) || (next_state == FL_POP);
      bus.tx_start <= (next_state == START);
    end
  end

  // Data capture, frame counter and inter-frame gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tx_data <= '0;
      frames_sent <= '0;
      gap_cnt     <= '0;
    end else begin
      if (state == LATCH) begin
        bus.tx_data <= bus.ff_data;
      end
      if ((state == SEND) && bus.tx_done) begin
        frames_sent <= frames_sent + 1'b1;
        gap_cnt     <= gap_ticks;
      end else if ((state == GAP) && b_en) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // Busy whenever the sequencer is anywhere but IDLE.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a FIFO model, a transmitter model
// that answers each tx_start with tx_done a fixed time later, a baud tick
// generator, and a scoreboard monitor fed with expected bytes by the
// stimulus process.
module tb_uart_tx_ctrl;
  localparam int TB_CNT_W = 4;
  localparam int FRAME    = 6;

  logic                clk;
  logic                rst;
  logic                enable;
  logic                flush;
  logic [7:0]          gap_ticks;
  logic                b_en;
  logic                busy;
  logic [TB_CNT_W-1:0] frames_sent;

  uart_tx_ctrl_if #(.D_W(8)) bus ();

  uart_tx_ctrl #(.D_W(8), .GAP_W(8), .CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .flush       (flush),
    .gap_ticks   (gap_ticks),
    .b_en        (b_en),
    .bus         (bus),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  int chk = 0;
  int err = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         exp_gap = 0;

  int                  cyc = 0;
  int                  rd_total = 0;
  int                  last_rd = -1;
  int                  fl_last = -1;
  logic                fl_mode = 1'b0;
  logic                in_frame = 1'b0;
  logic [7:0]          hold = '0;
  logic                pend = 1'b0;
  logic [TB_CNT_W-1:0] model = '0;
  logic                counting = 1'b0;
  int                  bcnt = 0;
  int                  tx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // FIFO model: pop on ff_rd_en, data valid the following cycle.
  always @(posedge clk) begin
    if (bus.ff_rd_en) begin
      check("pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) bus.ff_data <= fifo_q.pop_front();
    end
    bus.ff_empty <= (fifo_q.size() == 0);
  end

  // Transmitter model: tx_done FRAME cycles after tx_start.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
      if (rst) begin
        tx_cnt = 0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) bus.tx_done = 1'b1;
      end else if (bus.tx_start) begin
        tx_cnt = FRAME;
      end
    end
  end

  // Baud tick: one cycle in four.
  initial begin
    int bc;
    bc = 0;
    b_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bc++;
      b_en = (bc % 4 == 0);
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_frame = 1'b0;
        counting = 1'b0;
        pend     = 1'b0;
        model    = '0;
      end else begin
        if (pend) begin
          check("frames_sent", 32'(frames_sent), 32'(model));
          pend = 1'b0;
        end
        if (counting) begin
          if (!busy) begin
            check("gap_ticks_seen", bcnt, exp_gap);
            counting = 1'b0;
          end else if (b_en) begin
            bcnt++;
          end
        end
        if (bus.tx_start) begin
          check("start_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("tx_data", bus.tx_data, exp_q.pop_front());
          hold     = bus.tx_data;
          in_frame = 1'b1;
        end
        if (bus.tx_done && in_frame) begin
          check("tx_data_stable", bus.tx_data, hold);
          in_frame = 1'b0;
          model    = model + 1'b1;
          pend     = 1'b1;
          counting = 1'b1;
          bcnt     = 0;
        end
        if (bus.ff_rd_en) begin
          rd_total++;
          if (fl_mode && fl_last >= 0) check("flush_spacing", cyc - fl_last, 2);
          if (last_rd >= 0) check("rd_spacing", (cyc - last_rd) >= 2, 1);
          fl_last = cyc;
          last_rd = cyc;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic expect_tx);
    fifo_q.push_back(b);
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic wait_idle(input logic need_empty, input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(!busy && (!need_empty || fifo_q.size() == 0)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < budget, 1);
  endtask

  task automatic wait_sig(input int which, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((which == 0) ? bus.tx_start : bus.tx_done) && n < budget);
    check("event_timeout", n < budget, 1);
  endtask

  initial begin
    int rd0;
    rst = 1'b1;
    enable = 1'b0;
    flush = 1'b0;
    gap_ticks = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", bus.ff_rd_en, 0);
    check("rst_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_frames", 32'(frames_sent), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single byte, latency.
    exp_gap = 0;
    push(8'hA5, 1'b1);
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    check("n_rd_en", bus.ff_rd_en, 0);
    @(negedge clk);
    check("n1_rd_en", bus.ff_rd_en, 1);
    check("n1_busy", busy, 1);
    @(negedge clk);
    check("n2_rd_en", bus.ff_rd_en, 0);
    @(negedge clk);
    check("n3_start", bus.tx_start, 1);
    check("n3_data", bus.tx_data, 8'hA5);
    wait_sig(1, 50);
    @(negedge clk);
    check("single_frames", 32'(frames_sent), 1);
    check("single_busy", busy, 0);

    // Back-to-back with gap of 3 baud ticks.
    @(posedge clk);
    #1;
    gap_ticks = 8'd3;
    exp_gap = 3;
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b1);
    wait_idle(1'b1, 2000);
    check("b2b_frames", 32'(frames_sent), 5);
    check("b2b_exp_empty", exp_q.size(), 0);

    // Enable dropped during SEND.
    @(posedge clk);
    #1;
    gap_ticks = '0;
    exp_gap = 0;
    push(8'h3C, 1'b1);
    push(8'h3D, 1'b0);
    push(8'h3E, 1'b0);
    wait_sig(0, 50);
    #1 enable = 1'b0;
    wait_idle(1'b0, 200);
    rd0 = rd_total;
    repeat (20) @(negedge clk);
    check("drop_no_pop", rd_total - rd0, 0);
    check("drop_left", fifo_q.size(), 2);
    check("drop_frames", 32'(frames_sent), 6);

    // Flush of 5 queued bytes.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i), 1'b0);
    @(posedge clk);
    #1;
    fl_mode = 1'b1;
    fl_last = -1;
    rd0 = rd_total;
    flush = 1'b1;
    wait_idle(1'b1, 200);
    check("flush_pops", rd_total - rd0, 5);
    check("flush_frames", 32'(frames_sent), 6);
    check("flush_busy", busy, 0);
    check("flush_tx_data", bus.tx_data, 8'h3C);
    @(posedge clk);
    #1;
    flush = 1'b0;
    fl_mode = 1'b0;

    // Asynchronous reset while tx_start is high.
    enable = 1'b1;
    push(8'h5A, 1'b1);
    wait_sig(0, 50);
    #1 rst = 1'b1;
    #1;
    check("arst_start", bus.tx_start, 0);
    check("arst_busy", busy, 0);
    check("arst_frames", 32'(frames_sent), 0);
    check("arst_tx_data", bus.tx_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Sixteen frames wrap the 4-bit counter back to 0.
    for (int i = 0; i < 16; i++) push(8'(i * 17), 1'b1);
    wait_idle(1'b1, 3000);
    check("wrap_frames", 32'(frames_sent), 0);
    check("wrap_hold_data", bus.tx_data, 8'hFF);
    check("wrap_exp_empty", exp_q.size(), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-path sequencer between the TX channel FIFO and the UART transmitter. Pops one byte at a time from the FIFO when enabled, presents it to the transmitter with a start pulse, and waits for frame completion. Inserts a programmable inter-frame gap counted in baud ticks, and supports a flush that drains the FIFO without transmitting. Sits in the UART top level, driven by the baud generator's tick enable.

## Interface
- D_W, 8, data width of FIFO and transmitter
- GAP_W, 8, width of the inter-frame gap counter
- CNT_W, 16, width of the frames-sent counter

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; permits starting new frames
- flush  in  1  level; requests FIFO drain without transmission
- gap_ticks  in  GAP_W  idle gap after each frame, in b_en pulses; 0 = no gap
- b_en  in  1  one-cycle baud tick enable from the baud generator
- ff_empty  in  1  TX FIFO empty flag
- ff_data  in  D_W  TX FIFO read data; valid the cycle after ff_rd_en
- ff_rd_en  out  1  TX FIFO pop, one-cycle pulse, registered
- tx_data  out  D_W  byte to transmitter, registered, held stable from tx_start until tx_done
- tx_start  out  1  one-cycle start pulse to transmitter, registered
- tx_done  in  1  one-cycle pulse from transmitter at end of stop bit
- busy  out  1  high whenever the state is not IDLE
- frames_sent  out  CNT_W  count of completed frames; wraps at all-ones to 0

## Operation
- States: IDLE, POP, LATCH, START, SEND, GAP, FL_POP, FL_WAIT.
- IDLE:
  - flush=1 and ff_empty=0 -> FL_POP. Flush has priority over enable.
  - Otherwise enable=1 and ff_empty=0 -> POP.
  - Otherwise stay in IDLE.
- POP: ff_rd_en=1 for exactly this cycle -> LATCH.
- LATCH: tx_data <= ff_data -> START.
- START: tx_start=1 for exactly this cycle -> SEND.
- SEND: wait for tx_done. tx_done is ignored in every other state.
- On tx_done in SEND:
  - frames_sent <= frames_sent + 1, modulo 2^CNT_W.
  - gap_ticks==0 -> IDLE; otherwise load gap counter with gap_ticks -> GAP.
- GAP: decrement the counter on each b_en. When a b_en arrives with counter==1 -> IDLE.
- Flush:
  - FL_POP: ff_rd_en=1 -> FL_WAIT.
  - FL_WAIT: one cycle with no pop, lets the empty flag settle. Then flush=1 and ff_empty=0 -> FL_POP; else -> IDLE.
  - Flushed bytes are never captured into tx_data and never counted.
- Dropping enable or raising flush never aborts a frame. The frame runs from POP through SEND, and the gap completes, before the new level takes effect in IDLE.
- Never more than one ff_rd_en per two cycles; ff_rd_en is never asserted while ff_empty was high in the previous state decision.
- The block never reads ff_data except in LATCH.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - ff_rd_en=0, tx_start=0, busy=0.
  - tx_data=0, frames_sent=0, gap counter=0.
- Reset mid-frame: tx_start and ff_rd_en drop in the same instant. Any popped but unsent byte is lost; this is intended.
- Latency, taking cycle N as IDLE seeing enable=1 and ff_empty=0:
  - N+1: ff_rd_en=1.
  - N+2: tx_data loaded at the clock edge ending the cycle.
  - N+3: tx_start=1.
  - busy goes high at N+1.
- tx_done at cycle M in SEND:
  - frames_sent updated at M+1.
  - With gap_ticks=0: IDLE at M+1, next ff_rd_en no earlier than M+2.
- Gap: exactly gap_ticks b_en pulses elapse in GAP before IDLE. gap_ticks is sampled only at GAP entry; changes during GAP are ignored.
- Flush rate: one pop per 2 cycles.
- Simultaneous tx_done and b_en in SEND: b_en does not count toward the gap.
- tx_data holds its value after the frame until the next LATCH.

## Test plan
- Single byte: FIFO holds 0xA5, enable=1, gap_ticks=0 -> ff_rd_en at N+1, tx_start at N+3 with tx_data=0xA5. After tx_done, frames_sent=1 and busy=0 the next cycle.
- Back-to-back: 4 bytes 0x01..0x04, gap_ticks=3 -> bytes sent in order. Exactly 3 b_en pulses separate each tx_done from the next ff_rd_en decision. frames_sent=4.
- Enable drop mid-frame: enable=0 during SEND -> current frame completes and counts; no further pop while FIFO still has 2 bytes.
- Flush: 5 bytes queued, flush=1 in IDLE -> exactly 5 ff_rd_en pulses spaced 2 cycles apart. No tx_start; frames_sent unchanged; IDLE once ff_empty=1.
- Async reset mid-SEND: rst pulse between clock edges -> tx_start=0, busy=0, frames_sent=0 immediately. Normal operation resumes after release.
- Counter wrap: preload frames_sent to 0xFFFF via forced traffic (or use CNT_W=4 with 16 frames) -> next completed frame gives 0.
